// File: rtl/pov_frame_player.sv
// Persistence-of-vision renderer: tracks blade angle from step/index sensors and
// plays animation frames from a writable pattern RAM, advancing every N revolutions.
module pov_frame_player #(
  parameter int LED_W          = 16,
  parameter int STEPS          = 360,
  parameter int FRAMES         = 4,
  parameter int REVS_PER_FRAME = 8,
  parameter int ANG_W          = $clog2(STEPS),
  parameter int FRM_W          = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fanclk,
  input  logic             idx,
  input  logic             enable,
  input  logic             wr_en,
  input  logic [FRM_W-1:0] wr_frame,
  input  logic [ANG_W-1:0] wr_col,
  input  logic [LED_W-1:0] wr_data,
  output logic [LED_W-1:0] led,
  output logic [ANG_W-1:0] angle,
  output logic [FRM_W-1:0] frame,
  output logic             sync_err
);

  localparam int DEPTH = FRAMES * STEPS;
  localparam int ADR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int REV_W = (REVS_PER_FRAME > 1) ? $clog2(REVS_PER_FRAME) : 1;

  localparam logic [ANG_W-1:0] ANG_LAST = ANG_W'(STEPS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAMES - 1);
  localparam logic [REV_W-1:0] REV_LAST = REV_W'(REVS_PER_FRAME - 1);

  logic [2:0]       fan_sr;
  logic [2:0]       idx_sr;
  logic             step_ev;
  logic             idx_ev;
  logic [ANG_W-1:0] angle_nxt;
  logic             rev_ev;
  logic             err_set;
  logic [REV_W-1:0] rev_cnt;
  logic [ADR_W-1:0] rd_addr;
  logic [ADR_W-1:0] wr_addr;
  logic             wr_ok;
  logic [LED_W-1:0] mem [DEPTH];

  // Bits [1:0] synchronise, bit [2] holds the previous synchronised level for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      fan_sr <= '0;
      idx_sr <= '0;
    end else begin
      fan_sr <= {fan_sr[1:0], fanclk};
      idx_sr <= {idx_sr[1:0], idx};
    end
  end

  assign step_ev = fan_sr[1] & ~fan_sr[2];
  assign idx_ev  = idx_sr[1] & ~idx_sr[2];

  // Index wins over a coincident step; the step is dropped.
  always_comb begin
    angle_nxt = angle;
    rev_ev    = 1'b0;
    err_set   = 1'b0;
    if (idx_ev) begin
      if (angle != ANG_LAST) begin
        angle_nxt = ANG_LAST;
        rev_ev    = 1'b1;
        err_set   = (angle != '0);
      end
    end else if (step_ev) begin
      if (angle == '0) begin
        angle_nxt = ANG_LAST;
        rev_ev    = 1'b1;
      end else begin
        angle_nxt = angle - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      angle    <= ANG_LAST;
      frame    <= '0;
      rev_cnt  <= '0;
      sync_err <= 1'b0;
    end else begin
      angle <= angle_nxt;
      if (err_set) sync_err <= 1'b1;
      if (rev_ev) begin
        if (rev_cnt == REV_LAST) begin
          rev_cnt <= '0;
          frame   <= (frame == FRM_LAST) ? '0 : frame + 1'b1;
        end else begin
          rev_cnt <= rev_cnt + 1'b1;
        end
      end
    end
  end

  assign rd_addr = ADR_W'(frame) * ADR_W'(STEPS) + ADR_W'(angle);
  assign wr_addr = ADR_W'(wr_frame) * ADR_W'(STEPS) + ADR_W'(wr_col);
  assign wr_ok   = wr_en && (wr_col <= ANG_LAST) && (wr_frame <= FRM_LAST);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  // Read samples the pre-write contents, so a same-address write shows up one read later.
  always_ff @(posedge clk) begin
    if (rst) led <= '0;
    else     led <= enable ? mem[rd_addr] : '0;
  end

endmodule

// File: tb/tb_pov_frame_player.sv
// Self-checking bench for pov_frame_player against a behavioural angle/frame/RAM model.
module tb_pov_frame_player;

  localparam int LED_W = 16;
  localparam int STEPS = 360;
  localparam int FRAMES = 2;
  localparam int RPF = 2;
  localparam int ANG_W = 9;
  localparam int FRM_W = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             fanclk = 1'b0;
  logic             idx = 1'b0;
  logic             enable = 1'b0;
  logic             wr_en = 1'b0;
  logic [FRM_W-1:0] wr_frame = '0;
  logic [ANG_W-1:0] wr_col = '0;
  logic [LED_W-1:0] wr_data = '0;
  logic [LED_W-1:0] led;
  logic [ANG_W-1:0] angle;
  logic [FRM_W-1:0] frame;
  logic             sync_err;

  pov_frame_player #(
    .LED_W(LED_W), .STEPS(STEPS), .FRAMES(FRAMES), .REVS_PER_FRAME(RPF)
  ) dut (
    .clk(clk), .rst(rst), .fanclk(fanclk), .idx(idx), .enable(enable),
    .wr_en(wr_en), .wr_frame(wr_frame), .wr_col(wr_col), .wr_data(wr_data),
    .led(led), .angle(angle), .frame(frame), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model
  int m_angle, m_frame, m_rev;
  bit m_err;
  logic [LED_W-1:0] m_ram [FRAMES][STEPS];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void model_reset();
    m_angle = STEPS - 1; m_frame = 0; m_rev = 0; m_err = 0;
  endfunction

  function automatic void model_rev();
    m_rev = m_rev + 1;
    if (m_rev == RPF) begin
      m_rev = 0;
      m_frame = (m_frame + 1) % FRAMES;
    end
  endfunction

  function automatic void model_event(input bit f, input bit i);
    if (i) begin
      if (m_angle != STEPS - 1) begin
        if (m_angle != 0) m_err = 1;
        m_angle = STEPS - 1;
        model_rev();
      end
    end else if (f) begin
      if (m_angle == 0) begin
        m_angle = STEPS - 1;
        model_rev();
      end else begin
        m_angle = m_angle - 1;
      end
    end
  endfunction

  function automatic logic [LED_W-1:0] exp_led();
    return enable ? m_ram[m_frame][m_angle] : '0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; tick(2); rst = 1'b0;
    model_reset();
  endtask

  // One sensor pulse; all effects have reached angle and led when this returns.
  task automatic pulse(input bit f, input bit i);
    fanclk = f; idx = i; tick(2);
    fanclk = 1'b0; idx = 1'b0; tick(2);
    model_event(f, i);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) pulse(1'b1, 1'b0);
  endtask

  task automatic ram_write(input int fr, input int col, input logic [LED_W-1:0] d);
    wr_en = 1'b1; wr_frame = FRM_W'(fr); wr_col = ANG_W'(col); wr_data = d;
    tick(1);
    wr_en = 1'b0;
    if (col < STEPS && fr < FRAMES) m_ram[fr][col] = d;
  endtask

  task automatic check_state(input string tag);
    n_total++;
    if (angle !== ANG_W'(m_angle)) $display("FAIL %s angle: got %0d expected %0d", tag, angle, m_angle);
    else n_pass++;
    n_total++;
    if (frame !== FRM_W'(m_frame)) $display("FAIL %s frame: got %0d expected %0d", tag, frame, m_frame);
    else n_pass++;
    n_total++;
    if (sync_err !== m_err) $display("FAIL %s sync_err: got %0b expected %0b", tag, sync_err, m_err);
    else n_pass++;
    n_total++;
    if (led !== exp_led()) $display("FAIL %s led: got %h expected %h", tag, led, exp_led());
    else n_pass++;
  endtask

  task automatic test_ram_load();
    for (int f = 0; f < FRAMES; f++)
      for (int c = 0; c < STEPS; c++)
        ram_write(f, c, LED_W'($urandom));
    ram_write(0, 359, 16'hFFFF);
    ram_write(0, 358, 16'h0007);
    ram_write(0, 50, 16'h0000);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(2);
    model_reset();
    check_state("reset");
    rst = 1'b0;
  endtask

  task automatic test_step_latency();
    fanclk = 1'b1;
    tick(1);
    n_total++;
    if (angle !== 9'd359) $display("FAIL lat_edge1 angle: got %0d expected 359", angle); else n_pass++;
    tick(1);
    n_total++;
    if (angle !== 9'd359) $display("FAIL lat_edge2 angle: got %0d expected 359", angle); else n_pass++;
    tick(1);
    n_total++;
    if (angle !== 9'd358) $display("FAIL lat_edge3 angle: got %0d expected 358", angle); else n_pass++;
    tick(17);
    n_total++;
    if (angle !== 9'd358) $display("FAIL held_level angle: got %0d expected 358", angle); else n_pass++;
    fanclk = 1'b0; tick(2);
    model_event(1'b1, 1'b0);
    check_state("after_held");
  endtask

  task automatic test_led_path();
    do_reset();
    enable = 1'b1; tick(2);
    n_total++;
    if (led !== 16'hFFFF) $display("FAIL led_idle: got %h expected ffff", led); else n_pass++;
    fanclk = 1'b1; tick(3);
    n_total++;
    if (angle !== 9'd358 || led !== 16'hFFFF)
      $display("FAIL led_lag: got angle %0d led %h expected 358 ffff", angle, led);
    else n_pass++;
    tick(1);
    n_total++;
    if (led !== 16'h0007) $display("FAIL led_new: got %h expected 0007", led); else n_pass++;
    fanclk = 1'b0; tick(2);
    model_event(1'b1, 1'b0);
    enable = 1'b0; tick(1);
    n_total++;
    if (led !== 16'h0000) $display("FAIL led_blank: got %h expected 0000", led); else n_pass++;
    check_state("blank");
  endtask

  task automatic test_collision();
    do_reset();
    enable = 1'b1;
    steps(STEPS - 1 - 50);
    check_state("at_col50");
    ram_write(0, 50, 16'hA5A5);
    n_total++;
    if (led !== 16'h0000) $display("FAIL collision_old: got %h expected 0000", led); else n_pass++;
    tick(1);
    n_total++;
    if (led !== 16'hA5A5) $display("FAIL collision_new: got %h expected a5a5", led); else n_pass++;
    ram_write(0, 400, 16'h1234);
    tick(1);
    check_state("bad_col_write");
  endtask

  task automatic test_frames();
    do_reset();
    enable = 1'b1;
    steps(360);
    check_state("rev1");
    steps(359);
    check_state("rev2_minus1");
    steps(1);
    check_state("rev2_frame1");
    steps(319);
    check_state("frame1_col40");
    steps(41);
    check_state("rev3");
    steps(360);
    check_state("rev4_wrap");
  endtask

  task automatic test_index();
    do_reset();
    enable = 1'b1;
    steps(159);
    check_state("at200");
    pulse(1'b0, 1'b1);
    check_state("idx_at200");
    steps(360);
    check_state("err_sticky");
    do_reset();
    tick(1);
    check_state("err_cleared");
    pulse(1'b0, 1'b1);
    check_state("idx_at359");
    steps(360);
    check_state("no_rev_from_aligned_idx");
    steps(359);
    check_state("at0");
    pulse(1'b0, 1'b1);
    check_state("idx_at0");
    steps(259);
    pulse(1'b1, 1'b1);
    check_state("step_idx_at100");
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(99);
      if (r < 65)       steps($urandom_range(1, 40));
      else if (r < 75)  pulse(1'b0, 1'b1);
      else if (r < 80)  pulse(1'b1, 1'b1);
      else if (r < 92) begin
        ram_write($urandom_range(1), $urandom_range(511), LED_W'($urandom));
        tick(1);
      end else begin
        enable = ~enable; tick(1);
      end
      check_state("random");
    end
  endtask

  initial begin
    test_ram_load();
    test_reset();
    test_step_latency();
    test_led_path();
    test_collision();
    test_frames();
    test_index();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
